uart_tx: RTL and testbench

Serial transmitter that serialises bytes from the debug unit onto the UART TX line. It sits directly downstream of the debug unit: it consumes the debug unit's byte/start strobe and returns a one-cycle done pulse that advances the debug unit's byte counters. Framing is 8N1 by default: 1 start bit, NB_DATA data bits LSB first, an optional parity bit, and a stop period. Bit timing comes from a 16x oversampling tick.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_rate_gen.sv | 17 +
 rtl/uart_tx.sv | 107 ++++++++++
 tb/tb_uart_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and the future receiver.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;
  localparam int NB_STATE    = 3;
  localparam int DEF_NB_DATA = 8;
  localparam int DEF_N_TICKS = 16;
  localparam int DEF_SB_TICK = 16;
  localparam logic [NB_STATE-1:0] ST_IDLE   = 3'd0;
  localparam logic [NB_STATE-1:0] ST_START  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_DATA   = 3'd2;
  localparam logic [NB_STATE-1:0] ST_PARITY = 3'd3;
  localparam logic [NB_STATE-1:0] ST_STOP   = 3'd4;
  typedef enum logic [NB_STATE-1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
`ifdef UART_TX_PARITY_EN
    PARITY = ST_PARITY,
`endif
    STOP  = ST_STOP
  } state_t;
  function automatic int calc_divisor(input int clk_freq, input int baud_rate, input int n_ticks);
    return clk_freq / (baud_rate * n_ticks);
  endfunction
endpackage

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: DIVISOR-modulo counter emitting a one-cycle oversampling tick.
module baud_rate_gen #(
  parameter int DIVISOR = 163
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int NB_CNT = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(DIVISOR - 1);
  logic [NB_CNT-1:0] cnt;
  assign o_tick = cnt == LAST;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) cnt <= '0;
    else cnt <= (i_clear || o_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser, 8N1 framing on a 16x oversampling tick.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA   = DEF_NB_DATA,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 19200,
  parameter int N_TICKS   = DEF_N_TICKS,
  parameter int SB_TICK   = DEF_SB_TICK
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);
  localparam int DIVISOR  = calc_divisor(CLK_FREQ, BAUD_RATE, N_TICKS);
  localparam int MAX_TICK = N_TICKS > SB_TICK ? N_TICKS : SB_TICK;
  localparam int NB_TICK  = MAX_TICK > 1 ? $clog2(MAX_TICK) : 1;
  localparam int NB_BIT   = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
  localparam logic [NB_TICK-1:0] BIT_LAST  = NB_TICK'(N_TICKS - 1);
  localparam logic [NB_TICK-1:0] STOP_LAST = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_BIT-1:0]  DATA_LAST = NB_BIT'(NB_DATA - 1);
  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_tx: CLK_FREQ / (BAUD_RATE*N_TICKS) must be at least 1");
  end
  state_t state, state_next;
  logic [NB_DATA-1:0] shreg, shreg_next;
  logic [NB_TICK-1:0] tick_cnt, tick_next;
  logic [NB_BIT-1:0] bit_idx, bit_next;
  logic tick, accept, tick_last, tx_next, done_next;
  assign accept = state == IDLE && i_tx_start;
  assign o_busy = state != IDLE || o_tx_done;
  // Clearing on acceptance makes every bit exactly N_TICKS*DIVISOR cycles long.
  baud_rate_gen #(.DIVISOR(DIVISOR)) u_baud (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(accept),
    .o_tick (tick)
  );
`ifdef UART_TX_PARITY_EN
  logic parity;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) parity <= 1'b0;
    else if (accept) parity <= ^i_tx_data;
`endif
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    tick_next  = tick_cnt;
    bit_next   = bit_idx;
    done_next  = 1'b0;
    tick_last  = tick && tick_cnt == (state == STOP ? STOP_LAST : BIT_LAST);
    if (tick && state != IDLE) tick_next = tick_last ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: if (i_tx_start) begin
        state_next = START;
        shreg_next = i_tx_data;
        tick_next  = '0;
        bit_next   = '0;
      end
      START: if (tick_last) state_next = DATA;
      DATA: if (tick_last) begin
        shreg_next = shreg >> 1;
        bit_next   = bit_idx == DATA_LAST ? '0 : bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (bit_idx == DATA_LAST) state_next = PARITY;
`else
        if (bit_idx == DATA_LAST) state_next = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick_last) state_next = STOP;
`endif
      STOP: if (tick_last) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    tx_next = state_next == START ? 1'b0 : state_next == DATA ? shreg_next[0] :
              state_next == PARITY ? parity : 1'b1;
`else
    tx_next = state_next == START ? 1'b0 : state_next == DATA ? shreg_next[0] : 1'b1;
`endif
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state     <= IDLE;
      shreg     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      tick_cnt  <= tick_next;
      bit_idx   <= bit_next;
      o_tx      <= tx_next;
      o_tx_done <= done_next;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at DIVISOR=2 (32 cycles per bit).
module tb_uart_tx;
  localparam int BIT = 32;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = BIT * (2 + 8 + P);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] data = 8'h00;
  logic tx, done, busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(31250)) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_tx_start(start),
    .i_tx_data (data),
    .o_tx      (tx),
    .o_tx_done (done),
    .o_busy    (busy)
  );
  // Expected line level at cycle i after the acceptance edge.
  function automatic logic exp_tx(input logic [7:0] d, input int i);
    if (i < BIT) return 1'b0;
    if (i < BIT * 9) return d[3'((i - BIT) / BIT)];
    if (P == 1 && i < BIT * 10) return ^d;
    return 1'b1;
  endfunction
  function automatic logic [2:0] exp_line(input logic [7:0] d, input int i);
    return {exp_tx(d, i), 1'(i <= FRAME), 1'(i == FRAME)};
  endfunction
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hold tx/busy/done=%b%b%b expected 100", tx, busy, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL idle cycle %0d tx/busy/done=%b%b%b expected 100", i, tx, busy, done);
      end
    end
  endtask
  task automatic test_single();
    @(negedge clk);
    data = 8'hA5;
    start = 1'b1;
    for (int i = 0; i <= FRAME + 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({tx, busy, done} !== exp_line(8'hA5, i)) begin
        errors++;
        $display("FAIL single_a5 cycle %0d tx/busy/done=%b%b%b expected %b", i, tx, busy, done, exp_line(8'hA5, i));
      end
    end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    data = 8'h01;
    start = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== exp_line(8'h01, i)) begin
        errors++;
        $display("FAIL b2b_first cycle %0d tx/busy/done=%b%b%b expected %b", i, tx, busy, done, exp_line(8'h01, i));
      end
      if (i == FRAME) data = 8'hFF;
    end
    for (int i = 0; i <= FRAME + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== exp_line(8'hFF, i)) begin
        errors++;
        $display("FAIL b2b_second cycle %0d tx/busy/done=%b%b%b expected %b", i, tx, busy, done, exp_line(8'hFF, i));
      end
      if (i == 100) data = 8'h00;
      if (i == FRAME) start = 1'b0;
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    data = 8'h5A;
    start = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_bit2 tx=%b expected 0", tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset tx/busy/done=%b%b%b expected 100", tx, busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_recover cycle %0d tx/busy/done=%b%b%b expected 100", i, tx, busy, done);
      end
    end
    data = 8'h3C;
    start = 1'b1;
    for (int i = 0; i <= FRAME + 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({tx, busy, done} !== exp_line(8'h3C, i)) begin
        errors++;
        $display("FAIL post_reset_3c cycle %0d tx/busy/done=%b%b%b expected %b", i, tx, busy, done, exp_line(8'h3C, i));
      end
    end
  endtask
  task automatic test_ignore_start();
    int n_done = 0;
    @(negedge clk);
    data = 8'h96;
    start = 1'b1;
    for (int i = 0; i <= FRAME + 40; i++) begin
      @(negedge clk);
      start = (i == 50 || i == 150);
      if (start) data = 8'h00;
      if (done) n_done++;
      checks++;
      if ({tx, busy, done} !== exp_line(8'h96, i)) begin
        errors++;
        $display("FAIL ignore_start cycle %0d tx/busy/done=%b%b%b expected %b", i, tx, busy, done, exp_line(8'h96, i));
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_start_done_count got %0d expected 1", n_done);
    end
  endtask
  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    for (int b = 0; b < 2; b++) begin
      int len = -1;
      logic par = 1'bx;
      @(negedge clk);
      data = bytes[b];
      start = 1'b1;
      for (int i = 0; i < FRAME + 50 && len < 0; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (i == BIT * 9 + 16) par = tx;
        if (done) len = i;
      end
      checks++;
      if (par !== (P == 1 ? ^bytes[b] : 1'b1)) begin
        errors++;
        $display("FAIL parity_bit byte %h got %b expected %b", bytes[b], par, (P == 1 ? ^bytes[b] : 1'b1));
      end
      checks++;
      if (len !== FRAME) begin
        errors++;
        $display("FAIL frame_length byte %h got %0d expected %0d", bytes[b], len, FRAME);
      end
      repeat (3) @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_ignore_start();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
